and2_gate: RTL and testbench
============================

// Module: and2_gate
// PURPOSE
//  - Bitwise 2-input AND primitive.
//  - Combinational result y = a & b, plus a registered copy and a per-bit rising-edge strobe.
//  - Leaf cell used in datapath glue logic.
//  - The combinational path is independent of clock and reset.
//    It must be correct even when clk/rst are undriven.
// PARAMETERS
//  - WIDTH  1   operand/result width in bits (>=1)
//  - CNT_W  16  width of the rising-edge event counter (>=2; used only with AND2_STATS_EN)
// PORTS
//  - clk        in   1        system clock, rising-edge active
//  - rst        in   1        reset, asynchronous, active-high
//  - a          in   WIDTH    operand A
//  - b          in   WIDTH    operand B
//  - y          out  WIDTH    combinational a & b
//  - y_q        out  WIDTH    y registered on clk
//  - y_rise     out  WIDTH    1-cycle strobe per bit: y_q went 0->1 this cycle
//  - rise_cnt   out  CNT_W    saturating count of cycles with any y_rise bit set
//                             (present only with AND2_STATS_EN)
// BEHAVIOUR
//  - Interface: one clock; reset is asynchronous and active-high.
//  - y = a & b, bitwise, purely combinational, zero-latency.
//    - No dependence on clk/rst state.
//    - Any X/Z input bit follows standard Verilog & semantics:
//      0 & X = 0, 1 & X = X.
//  - Reset (rst=1, asserted asynchronously, held any duration):
//    - y_q = 0, y_rise = 0, internal prev register = 0, rise_cnt = 0.
//    - y still tracks a & b during reset.
//  - Reset release is synchronous to the next rising clk edge; no partial-cycle update.
//  - Each rising clk edge with rst=0:
//    - y_q <= a & b (1-cycle latency).
//    - y_rise <= (a & b) & ~y_q, i.e. asserted in the same cycle y_q first shows the 1.
//  - y_rise is high for exactly one cycle per 0->1 transition of each y_q bit.
//    - A steady 1 never re-strobes.
//    - 1->0 transitions do not strobe.
//  - First sample after reset:
//    - prev = 0, so any bit sampled as 1 strobes.
//  - Input glitches between clock edges:
//    - Visible on y.
//    - Invisible to y_q / y_rise.
//  - Reset mid-operation:
//    - All registered outputs are cleared immediately (asynchronously).
//    - A pending strobe is discarded.
// CONFIGURATION
//  - Macro AND2_STATS_EN defined:
//    - rise_cnt port exists.
//    - Increments by 1 on each clk edge where |y_rise_next is 1.
//    - Saturates at 2^CNT_W-1 (no wrap).
//    - Cleared only by rst.
//  - Macro AND2_STATS_EN undefined:
//    - rise_cnt port and counter logic are absent.
//    - All other behaviour is identical.
// TESTING
//  - Truth table, clk/rst undriven, WIDTH=1, 10 ns steps:
//    - (a,b) = 00, 01, 10, 11 -> y = 0, 0, 0, 1, settled within each step.
//    - Dump VCD.
//  - Reset: rst=1 with a=b=1 -> y=1, y_q=0, y_rise=0.
//    - Release, one edge later -> y_q=1, y_rise=1.
//    - Next edge -> y_rise=0.
//  - Toggle: a=1, b toggled 1,0,1 on successive edges -> y_rise = 1,0,1 pattern after the
//    1-cycle latency; no strobe on the falling transition.
//  - Async reset: assert rst between edges while y_q=1 -> y_q, y_rise go 0 immediately,
//    before the next edge.
//  - WIDTH=4:
//    - a=4'b1100, b=4'b1010 -> y=4'b1000.
//    - Then b=4'b1110 -> next edge y_q=4'b1100, y_rise=4'b0100.
//  - AND2_STATS_EN, CNT_W=2: generate 5 rise events -> rise_cnt = 1, 2, 3, 3, 3 (saturates).

Source files
------------

// File: rtl/and2_gate_if.sv
// ---------------------------------------------------------------------------
// and2_gate_if
//
// Purpose : Bundles the operand and result signals of the and2_gate leaf
//           cell so that a driver and the cell share one connection point.
//
// Parameters
//   WIDTH : operand/result width in bits (>= 1)
//   CNT_W : width of the rising-edge event counter (>= 2)
//
// Signals
//   a, b     : operands, driven by the master
//   y        : combinational a & b
//   y_q      : registered copy of y
//   y_rise   : one-cycle per-bit strobe when y_q goes 0->1
//   rise_cnt : saturating rise-event count (only with AND2_STATS_EN)
//
// Modports
//   master : drives a/b, observes the results (bench or upstream logic)
//   slave  : consumes a/b, produces the results (the and2_gate cell)
//
// Build option: define AND2_STATS_EN to add the rise_cnt signal.
// ---------------------------------------------------------------------------
interface and2_gate_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) ();

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] y_rise;

`ifdef AND2_STATS_EN
  logic [CNT_W-1:0] rise_cnt;

  modport master (
    output a,
    output b,
    input  y,
    input  y_q,
    input  y_rise,
    input  rise_cnt
  );

  modport slave (
    input  a,
    input  b,
    output y,
    output y_q,
    output y_rise,
    output rise_cnt
  );
`else
  modport master (
    output a,
    output b,
    input  y,
    input  y_q,
    input  y_rise
  );

  modport slave (
    input  a,
    input  b,
    output y,
    output y_q,
    output y_rise
  );
`endif

  // Elaboration-time guard against illegal parameter combinations.
  if (WIDTH < 1) begin : g_bad_width
    $error("and2_gate_if: WIDTH must be >= 1");
  end
  if (CNT_W < 2) begin : g_bad_cnt_w
    $error("and2_gate_if: CNT_W must be >= 2");
  end

endinterface

// File: rtl/and2_gate.sv
// ---------------------------------------------------------------------------
// and2_gate
//
// Purpose : Bitwise 2-input AND leaf cell for datapath glue logic.
//           Provides the zero-latency result y = a & b, a registered copy
//           y_q, and a per-bit one-cycle strobe y_rise that fires in the
//           same cycle y_q first shows a 1.
//
// Parameters
//   WIDTH : operand/result width in bits (>= 1)
//   CNT_W : rise-event counter width (>= 2), used only with AND2_STATS_EN
//
// Ports
//   clk : system clock, rising-edge active
//   rst : asynchronous, active-high reset; release takes effect on the
//         next rising clk edge
//   bus : and2_gate_if.slave
//           a, b     (in)  operands
//           y        (out) combinational a & b, independent of clk/rst
//           y_q      (out) a & b registered on clk
//           y_rise   (out) per-bit strobe: y_q went 0->1 this cycle
//           rise_cnt (out) saturating count of edges with any rise bit set
//                          (only with AND2_STATS_EN)
//
// Build option: define AND2_STATS_EN to add the saturating rise counter.
//               Without it the counter and its port are absent and all other
//               behaviour is unchanged.
// ---------------------------------------------------------------------------
module and2_gate #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  and2_gate_if.slave bus
);

  logic [WIDTH-1:0] and_s;
  logic [WIDTH-1:0] y_rise_next_s;
  logic [WIDTH-1:0] y_q_r;
  logic [WIDTH-1:0] y_rise_r;

  // Combinational AND; plain & keeps X/Z propagation (0&X=0, 1&X=X) and has
  // no dependence on clk or rst, so y stays valid even during reset.
  assign and_s = bus.a & bus.b;
  assign bus.y = and_s;

  // Rise detection: y_q_r doubles as the "previous sample" register, so a bit
  // strobes only when it is sampled as 1 while the stored copy is still 0.
  always_comb begin
    y_rise_next_s = and_s & ~y_q_r;
  end

  // Registered copy and strobe; an asynchronous reset also drops any strobe
  // that would have been captured on the next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q_r    <= {WIDTH{1'b0}};
      y_rise_r <= {WIDTH{1'b0}};
    end else begin
      y_q_r    <= and_s;
      y_rise_r <= y_rise_next_s;
    end
  end

  assign bus.y_q    = y_q_r;
  assign bus.y_rise = y_rise_r;

`ifdef AND2_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] rise_cnt_next_s;
  logic [CNT_W-1:0] rise_cnt_r;

  // Saturating event count: one step per edge with any rising bit, holding
  // at all-ones instead of wrapping.
  always_comb begin
    rise_cnt_next_s = rise_cnt_r;
    if ((|y_rise_next_s) && (rise_cnt_r != CNT_MAX)) begin
      rise_cnt_next_s = rise_cnt_r + CNT_ONE;
    end else begin
      rise_cnt_next_s = rise_cnt_r;
    end
  end

  // Counter register, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_cnt_r <= {CNT_W{1'b0}};
    end else begin
      rise_cnt_r <= rise_cnt_next_s;
    end
  end

  assign bus.rise_cnt = rise_cnt_r;
`endif

  // Elaboration-time guard against illegal parameter combinations.
  if (WIDTH < 1) begin : g_bad_width
    $error("and2_gate: WIDTH must be >= 1");
  end
  if (CNT_W < 2) begin : g_bad_cnt_w
    $error("and2_gate: CNT_W must be >= 2");
  end

endmodule

// File: tb/tb_and2_gate.sv
// ---------------------------------------------------------------------------
// tb_and2_gate
//
// Self-checking bench for and2_gate. Two instances are exercised: a 1-bit
// cell and a 4-bit cell (CNT_W=2 so the counter saturates quickly when
// AND2_STATS_EN is defined). Expected results are queued when stimulus is
// driven and popped when the registered outputs are sampled, 1 ns after the
// rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_and2_gate;

  logic clk;
  logic rst;

  and2_gate_if #(.WIDTH(1), .CNT_W(16)) bus1 ();
  and2_gate_if #(.WIDTH(4), .CNT_W(2))  bus4 ();

  and2_gate #(.WIDTH(1), .CNT_W(16)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  and2_gate #(.WIDTH(4), .CNT_W(2)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  typedef struct packed {
    logic [3:0] y;
    logic [3:0] q;
    logic [3:0] rise;
  } exp_t;

  exp_t sb1[$];
  exp_t sb4[$];
`ifdef AND2_STATS_EN
  logic [1:0] cnt_sb[$];
`endif

  int n_vec = 0;
  int n_err = 0;

  // Free-running clock, 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Runaway guard.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded 100000 ns, expected completion");
    $fatal(1, "watchdog expired");
  end

  // Drive the 1-bit cell on the falling edge and queue its expected result.
  task automatic drive1(input logic a, input logic b, input exp_t e);
    @(negedge clk);
    bus1.a = a;
    bus1.b = b;
    sb1.push_back(e);
  endtask

  // Drive the 4-bit cell on the falling edge and queue its expected result.
  task automatic drive4(input logic [3:0] a, input logic [3:0] b, input exp_t e);
    @(negedge clk);
    bus4.a = a;
    bus4.b = b;
    sb4.push_back(e);
  endtask

  // Truth table on the 1-bit cell before rst has ever been driven.
  task automatic test_truth_table();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      bus1.a = (i >= 2) ? 1'b1 : 1'b0;
      bus1.b = (i % 2 == 1) ? 1'b1 : 1'b0;
      sb1.push_back('{y: (i == 3) ? 4'b0001 : 4'b0000, q: 4'b0000, rise: 4'b0000});
      #9;
      e = sb1.pop_front();
      n_vec++;
      if (bus1.y !== e.y[0]) begin
        n_err++;
        $display("FAIL truth[%0d]: y=%b, expected %b", i, bus1.y, e.y[0]);
      end
      #1;
    end
  endtask

  // Reset holds registers at zero while y tracks a & b; release strobes once.
  task automatic test_reset();
    rst    = 1'b1;
    bus1.a = 1'b1;
    bus1.b = 1'b1;
    bus4.a = 4'hF;
    bus4.b = 4'hF;
    #3;
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (bus1.y !== 1'b1 || bus1.y_q !== 1'b0 || bus1.y_rise !== 1'b0) begin
        n_err++;
        $display("FAIL reset1[%0d]: y=%b y_q=%b y_rise=%b, expected 1 0 0",
                 k, bus1.y, bus1.y_q, bus1.y_rise);
      end
      n_vec++;
      if (bus4.y !== 4'hF || bus4.y_q !== 4'h0 || bus4.y_rise !== 4'h0) begin
        n_err++;
        $display("FAIL reset4[%0d]: y=%h y_q=%h y_rise=%h, expected f 0 0",
                 k, bus4.y, bus4.y_q, bus4.y_rise);
      end
`ifdef AND2_STATS_EN
      n_vec++;
      if (bus4.rise_cnt !== 2'd0) begin
        n_err++;
        $display("FAIL reset_cnt[%0d]: rise_cnt=%0d, expected 0", k, bus4.rise_cnt);
      end
`endif
      // Second pass: reset held across a clock edge.
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    rst = 1'b0;
    sb1.push_back('{y: 4'b0001, q: 4'b0001, rise: 4'b0001});
    sb1.push_back('{y: 4'b0001, q: 4'b0001, rise: 4'b0000});
    sb4.push_back('{y: 4'hF, q: 4'hF, rise: 4'hF});
    sb4.push_back('{y: 4'hF, q: 4'hF, rise: 4'h0});
    for (int k = 0; k < 2; k++) begin
      exp_t e1;
      exp_t e4;
      @(posedge clk);
      #1;
      e1 = sb1.pop_front();
      e4 = sb4.pop_front();
      n_vec++;
      if (bus1.y_q !== e1.q[0] || bus1.y_rise !== e1.rise[0]) begin
        n_err++;
        $display("FAIL release1[%0d]: y_q=%b y_rise=%b, expected %b %b",
                 k, bus1.y_q, bus1.y_rise, e1.q[0], e1.rise[0]);
      end
      n_vec++;
      if (bus4.y_q !== e4.q || bus4.y_rise !== e4.rise) begin
        n_err++;
        $display("FAIL release4[%0d]: y_q=%h y_rise=%h, expected %h %h",
                 k, bus4.y_q, bus4.y_rise, e4.q, e4.rise);
      end
    end
  endtask

  // a=1, b toggles: strobe on each 0->1, none on 1->0 or on a steady 1.
  task automatic test_toggle();
    logic b_seq [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic q_exp [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic r_exp [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      drive1(1'b1, b_seq[i], '{y: {3'b000, b_seq[i]}, q: {3'b000, q_exp[i]},
                               rise: {3'b000, r_exp[i]}});
      @(posedge clk);
      #1;
      e = sb1.pop_front();
      n_vec++;
      if (bus1.y_q !== e.q[0] || bus1.y_rise !== e.rise[0]) begin
        n_err++;
        $display("FAIL toggle[%0d]: y_q=%b y_rise=%b, expected %b %b",
                 i, bus1.y_q, bus1.y_rise, e.q[0], e.rise[0]);
      end
    end
  endtask

  // Multi-bit behaviour: each bit strobes independently.
  task automatic test_width4();
    logic [3:0] a_tab [3] = '{4'b0000, 4'b1100, 4'b1100};
    logic [3:0] b_tab [3] = '{4'b0000, 4'b1010, 4'b1110};
    logic [3:0] y_tab [3] = '{4'b0000, 4'b1000, 4'b1100};
    logic [3:0] r_tab [3] = '{4'b0000, 4'b1000, 4'b0100};
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      drive4(a_tab[i], b_tab[i], '{y: y_tab[i], q: y_tab[i], rise: r_tab[i]});
      #1;
      n_vec++;
      if (bus4.y !== y_tab[i]) begin
        n_err++;
        $display("FAIL width4_y[%0d]: y=%b, expected %b", i, bus4.y, y_tab[i]);
      end
      @(posedge clk);
      #1;
      e = sb4.pop_front();
      n_vec++;
      if (bus4.y_q !== e.q || bus4.y_rise !== e.rise) begin
        n_err++;
        $display("FAIL width4[%0d]: y_q=%b y_rise=%b, expected %b %b",
                 i, bus4.y_q, bus4.y_rise, e.q, e.rise);
      end
    end
  endtask

  // A glitch between edges shows on y but never reaches y_q / y_rise.
  task automatic test_glitch();
    exp_t e;
    drive4(4'hF, 4'hF, '{y: 4'hF, q: 4'hF, rise: 4'b0011});
    @(posedge clk);
    #1;
    e = sb4.pop_front();
    n_vec++;
    if (bus4.y_q !== e.q || bus4.y_rise !== e.rise) begin
      n_err++;
      $display("FAIL glitch_setup: y_q=%b y_rise=%b, expected %b %b",
               bus4.y_q, bus4.y_rise, e.q, e.rise);
    end
    #1;
    bus4.b = 4'h0;
    #1;
    n_vec++;
    if (bus4.y !== 4'h0 || bus4.y_q !== 4'hF) begin
      n_err++;
      $display("FAIL glitch_y: y=%b y_q=%b, expected 0000 1111", bus4.y, bus4.y_q);
    end
    #1;
    bus4.b = 4'hF;
    sb4.push_back('{y: 4'hF, q: 4'hF, rise: 4'h0});
    @(posedge clk);
    #1;
    e = sb4.pop_front();
    n_vec++;
    if (bus4.y_q !== e.q || bus4.y_rise !== e.rise) begin
      n_err++;
      $display("FAIL glitch_edge: y_q=%b y_rise=%b, expected %b %b",
               bus4.y_q, bus4.y_rise, e.q, e.rise);
    end
  endtask

  // Reset between edges clears registered outputs at once and drops a
  // pending strobe; after release the first 1 sample strobes again.
  task automatic test_async_reset();
    exp_t e;
    drive4(4'h0, 4'h0, '{y: 4'h0, q: 4'h0, rise: 4'h0});
    @(posedge clk);
    #1;
    e = sb4.pop_front();
    drive4(4'hF, 4'hF, '{y: 4'hF, q: 4'hF, rise: 4'hF});
    @(posedge clk);
    #1;
    e = sb4.pop_front();
    n_vec++;
    if (bus4.y_q !== e.q || bus4.y_rise !== e.rise) begin
      n_err++;
      $display("FAIL async_setup: y_q=%b y_rise=%b, expected %b %b",
               bus4.y_q, bus4.y_rise, e.q, e.rise);
    end
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if (bus4.y_q !== 4'h0 || bus4.y_rise !== 4'h0 || bus1.y_q !== 1'b0 || bus4.y !== 4'hF) begin
      n_err++;
      $display("FAIL async_clear: y_q=%b y_rise=%b y_q1=%b y=%b, expected 0000 0000 0 1111",
               bus4.y_q, bus4.y_rise, bus1.y_q, bus4.y);
    end
    @(negedge clk);
    rst = 1'b0;
    bus4.a = 4'h0;
    // Pending strobe: inputs go high, then reset lands before the edge.
    @(negedge clk);
    bus4.a = 4'hF;
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if (bus4.y_q !== 4'h0 || bus4.y_rise !== 4'h0) begin
      n_err++;
      $display("FAIL async_pending: y_q=%b y_rise=%b, expected 0000 0000",
               bus4.y_q, bus4.y_rise);
    end
    @(negedge clk);
    rst = 1'b0;
    sb4.push_back('{y: 4'hF, q: 4'hF, rise: 4'hF});
    @(posedge clk);
    #1;
    e = sb4.pop_front();
    n_vec++;
    if (bus4.y_q !== e.q || bus4.y_rise !== e.rise) begin
      n_err++;
      $display("FAIL async_release: y_q=%b y_rise=%b, expected %b %b",
               bus4.y_q, bus4.y_rise, e.q, e.rise);
    end
  endtask

  // Back-to-back random operands against a reference model of the strobe.
  task automatic test_random();
    logic [3:0] m_q;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] ry;
    exp_t e;
    drive4(4'h0, 4'h0, '{y: 4'h0, q: 4'h0, rise: 4'h0});
    @(posedge clk);
    #1;
    e = sb4.pop_front();
    m_q = 4'h0;
    for (int i = 0; i < 40; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      ry = ra & rb;
      drive4(ra, rb, '{y: ry, q: ry, rise: ry & ~m_q});
      m_q = ry;
      #1;
      n_vec++;
      if (bus4.y !== ry) begin
        n_err++;
        $display("FAIL rand_y[%0d]: y=%b, expected %b", i, bus4.y, ry);
      end
      @(posedge clk);
      #1;
      e = sb4.pop_front();
      n_vec++;
      if (bus4.y_q !== e.q || bus4.y_rise !== e.rise) begin
        n_err++;
        $display("FAIL rand[%0d]: y_q=%b y_rise=%b, expected %b %b",
                 i, bus4.y_q, bus4.y_rise, e.q, e.rise);
      end
    end
  endtask

`ifdef AND2_STATS_EN
  // Five rise events on a 2-bit counter: 1, 2, 3, then held at 3.
  task automatic test_stats();
    logic [1:0] c_tab [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    logic [1:0] c;
    @(negedge clk);
    rst = 1'b1;
    bus4.a = 4'h0;
    bus4.b = 4'h0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus4.a = 4'hF;
      bus4.b = 4'hF;
      cnt_sb.push_back(c_tab[i]);
      @(posedge clk);
      #1;
      c = cnt_sb.pop_front();
      n_vec++;
      if (bus4.rise_cnt !== c) begin
        n_err++;
        $display("FAIL stats[%0d]: rise_cnt=%0d, expected %0d", i, bus4.rise_cnt, c);
      end
      @(negedge clk);
      bus4.a = 4'h0;
    end
  endtask
`endif

  // Test sequence.
  initial begin
    bus1.a = 1'b0;
    bus1.b = 1'b0;
    bus4.a = 4'h0;
    bus4.b = 4'h0;
    test_truth_table();
    test_reset();
    test_toggle();
    test_width4();
    test_glitch();
    test_async_reset();
    test_random();
`ifdef AND2_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
